// File: rtl/issue_arbiter_rr_pkg.sv
// Shared definitions for arbiters that feed one execution unit from several issue buffers.
// Provides the default instruction width, the instruction word type and the source-index width helper.
package issue_pkg;

    localparam int DATA_WIDTH_DEF = 47;
    localparam int CD_W           = 4;

    typedef logic [DATA_WIDTH_DEF-1:0] instr_t;

    // Index width able to name every requester, never narrower than one bit.
    function automatic int src_width(input int num_req);
        int w;
        w = $clog2(num_req);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/issue_arbiter_rr_rr_pick.sv
// Rotating-priority selector: searches req starting just after position last, wrapping around,
// and returns the first set position as one-hot grant plus binary index.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] cand_s;

    // Walk the N positions following last in priority order; the first request seen wins.
    always_comb begin
        grant  = {N{1'b0}};
        idx    = {PW{1'b0}};
        any    = 1'b0;
        cand_s = {PW{1'b0}};
        for (int off = 1; off <= N; off++) begin
            cand_s = PW'((int'(last) + off) % N);
            if (!any && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                idx           = cand_s;
                any           = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/issue_arbiter_rr.sv
// Issue arbiter: NUM_REQ issue buffers share one execution unit through a single-entry output register.
// Build macro ISSUE_ARB_PRIO0_EN gives requester 0 absolute priority over the round-robin group.
module issue_arbiter_rr
    import issue_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int NUM_REQ       = 3,
    parameter int INIT_INTERVAL = 1,
    parameter int SRC_W         = src_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         issue_data,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [SRC_W-1:0]              issue_src
);

    localparam logic [CD_W-1:0]  CD_RELOAD  = CD_W'(INIT_INTERVAL - 1);
    localparam logic [SRC_W-1:0] LAST_RESET = SRC_W'(NUM_REQ - 1);

    logic [DATA_WIDTH-1:0] issue_data_r;
    logic                  issue_valid_r;
    logic [SRC_W-1:0]      issue_src_r;
    logic [SRC_W-1:0]      last_grant_r;
    logic [CD_W-1:0]       cooldown_r;

    logic                  slot_free_s;
    logic                  can_grant_s;
    logic                  xfer_s;
    logic                  ptr_upd_s;
    logic [NUM_REQ-1:0]    pick_req_s;
    logic [NUM_REQ-1:0]    pick_grant_s;
    logic [SRC_W-1:0]      pick_idx_s;
    logic                  pick_any_s;
    logic [NUM_REQ-1:0]    win_grant_s;
    logic [SRC_W-1:0]      win_idx_s;
    logic                  win_any_s;
    logic [DATA_WIDTH-1:0] win_data_s;

`ifdef ISSUE_ARB_PRIO0_EN
    localparam logic [NUM_REQ-1:0] REQ0_MASK = NUM_REQ'(1);

    // Requester 0 stands outside the rotation; the rest share it.
    always_comb begin
        pick_req_s = req_valid & ~REQ0_MASK;
    end

    // Requester 0 overrides the rotating pick and leaves the pointer alone.
    always_comb begin
        if (req_valid[0]) begin
            win_grant_s = REQ0_MASK;
            win_idx_s   = {SRC_W{1'b0}};
            win_any_s   = 1'b1;
            ptr_upd_s   = 1'b0;
        end else begin
            win_grant_s = pick_grant_s;
            win_idx_s   = pick_idx_s;
            win_any_s   = pick_any_s;
            ptr_upd_s   = 1'b1;
        end
    end
`else
    // Every requester takes part in the rotation.
    always_comb begin
        pick_req_s = req_valid;
    end

    // The rotating pick is the winner and every grant moves the pointer.
    always_comb begin
        win_grant_s = pick_grant_s;
        win_idx_s   = pick_idx_s;
        win_any_s   = pick_any_s;
        ptr_upd_s   = 1'b1;
    end
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .PW (SRC_W)
    ) u_pick (
        .req   (pick_req_s),
        .last  (last_grant_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // Grant qualification: ready is a function of valids and arbiter state only, never of data.
    always_comb begin
        slot_free_s = !issue_valid_r || issue_ready;
        can_grant_s = slot_free_s && (cooldown_r == {CD_W{1'b0}}) && !flush && !rst;
        if (can_grant_s) begin
            req_ready = win_grant_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
        xfer_s = can_grant_s && win_any_s;
    end

    // Select the winning requester's instruction slice.
    always_comb begin
        win_data_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx_s == SRC_W'(i)) begin
                win_data_s = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Output register, cooldown and pointer. Cooldown restarts on each accepted transfer so that
    // streaming issues reach the unit INIT_INTERVAL cycles apart; flush cancels it.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_r <= 1'b0;
            issue_data_r  <= {DATA_WIDTH{1'b0}};
            issue_src_r   <= {SRC_W{1'b0}};
            last_grant_r  <= LAST_RESET;
            cooldown_r    <= {CD_W{1'b0}};
        end else begin
            if (flush) begin
                cooldown_r <= {CD_W{1'b0}};
            end else if (xfer_s) begin
                cooldown_r <= CD_RELOAD;
            end else if (cooldown_r != {CD_W{1'b0}}) begin
                cooldown_r <= cooldown_r - CD_W'(1);
            end

            if (flush) begin
                issue_valid_r <= 1'b0;
            end else if (xfer_s) begin
                issue_valid_r <= 1'b1;
            end else if (issue_ready) begin
                issue_valid_r <= 1'b0;
            end

            if (xfer_s) begin
                issue_data_r <= win_data_s;
                issue_src_r  <= win_idx_s;
                if (ptr_upd_s) begin
                    last_grant_r <= win_idx_s;
                end
            end
        end
    end

    assign issue_valid = issue_valid_r;
    assign issue_data  = issue_data_r;
    assign issue_src   = issue_src_r;

endmodule

// File: tb/tb_issue_arbiter_rr.sv
// Directed bench for issue_arbiter_rr: per-cycle vector tables with hand-computed grants,
// plus a reset-mid-stall sequence. Two instances share stimulus (INIT_INTERVAL 1 and 3).
module tb_issue_arbiter_rr;

    localparam int DW = 47;
    localparam int NR = 3;

    typedef struct packed {
        logic       sel;
        logic       rs;
        logic       fl;
        logic [2:0] rv;
        logic       ir;
        logic [2:0] err;
        logic       ev;
        logic [1:0] es;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             issue_ready;
    logic [NR-1:0]    req_valid;
    logic [DW*NR-1:0] req_data;
    logic [NR-1:0]    rr1, rr3;
    logic [DW-1:0]    d1, d3;
    logic             v1, v3;
    logic [1:0]       s1, s3;
    logic [DW-1:0]    dat [NR];
    vec_t             tab1 [$];
    vec_t             tab3 [$];
    int               checks = 0;
    int               failures = 0;

    issue_arbiter_rr #(.DATA_WIDTH(DW), .NUM_REQ(NR), .INIT_INTERVAL(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .req_data(req_data), .req_valid(req_valid),
        .req_ready(rr1), .issue_data(d1), .issue_valid(v1), .issue_ready(issue_ready), .issue_src(s1)
    );

    issue_arbiter_rr #(.DATA_WIDTH(DW), .NUM_REQ(NR), .INIT_INTERVAL(3)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush), .req_data(req_data), .req_valid(req_valid),
        .req_ready(rr3), .issue_data(d3), .issue_valid(v3), .issue_ready(issue_ready), .issue_src(s3)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic sel, input logic rs, input logic fl, input logic [2:0] rv,
                                input logic ir, input logic [2:0] err, input logic ev, input logic [1:0] es);
        vec_t v;
        v.sel = sel; v.rs = rs; v.fl = fl; v.rv = rv; v.ir = ir;
        v.err = err; v.ev = ev; v.es = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check req_ready before the edge, registered outputs after it.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rs; flush = v.fl; req_valid = v.rv; issue_ready = v.ir;
        #1;
        check({tag, " req_ready"}, 64'(v.sel ? rr3 : rr1), 64'(v.err));
        @(posedge clk);
        #1;
        check({tag, " issue_valid"}, 64'(v.sel ? v3 : v1), 64'(v.ev));
        if (v.ev) begin
            check({tag, " issue_src"}, 64'(v.sel ? s3 : s1), 64'(v.es));
            check({tag, " issue_data"}, 64'(v.sel ? d3 : d1), 64'(dat[v.es]));
        end
    endtask

    initial begin
        dat[0] = 47'h0000_0000_1111;
        dat[1] = 47'h0000_0000_1234;
        dat[2] = 47'h7_0000_3333;
        req_data = {dat[2], dat[1], dat[0]};
        rst = 1'b1; flush = 1'b0; req_valid = 3'b000; issue_ready = 1'b0;

`ifdef ISSUE_ARB_PRIO0_EN
        // Requester 0 dominates; 1 and 2 rotate whenever it drops out.
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b110, 1'b1, 3'b010, 1'b1, 2'd1));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b110, 1'b1, 3'b100, 1'b1, 2'd2));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b110, 1'b1, 3'b010, 1'b1, 2'd1));
`else
        // Saturation: rotation 0,1,2,0,1,2.
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2));
        // Drain with no requests, then an idle cycle that must not rotate.
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0));
        // Requester 1 alone, four stall cycles, then regranted.
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 3'b010, 1'b1, 2'd1));
        for (int k = 0; k < 4; k++)
            tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 3'b000, 1'b1, 2'd1));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1));
        // Skip over the idle requester 1.
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b101, 1'b1, 3'b100, 1'b1, 2'd2));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b101, 1'b1, 3'b001, 1'b1, 2'd0));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b101, 1'b1, 3'b100, 1'b1, 2'd2));
        // Single persistent requester.
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0));
        // Flush of a held instruction from 2; pointer stays at 2 so 0 is next.
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 3'b100, 1'b1, 2'd2));
        tab1.push_back(mk(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 3'b000, 1'b0, 2'd0));
        tab1.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 3'b001, 1'b1, 2'd0));
        tab1.push_back(mk(1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0));

        // INIT_INTERVAL=3 instance: unit sees src 0,2,0 three cycles apart.
        tab3.push_back(mk(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0));
        tab3.push_back(mk(1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 3'b001, 1'b1, 2'd0));
        tab3.push_back(mk(1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 3'b000, 1'b0, 2'd0));
        tab3.push_back(mk(1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 3'b000, 1'b0, 2'd0));
        tab3.push_back(mk(1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 3'b100, 1'b1, 2'd2));
        tab3.push_back(mk(1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 3'b000, 1'b0, 2'd0));
        tab3.push_back(mk(1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 3'b000, 1'b0, 2'd0));
        tab3.push_back(mk(1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 3'b001, 1'b1, 2'd0));
        // Flush cancels the cooldown: grant resumes the very next cycle.
        tab3.push_back(mk(1'b1, 1'b0, 1'b1, 3'b101, 1'b1, 3'b000, 1'b0, 2'd0));
        tab3.push_back(mk(1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 3'b100, 1'b1, 2'd2));
        // Reset while cooling down clears the counter and the pointer.
        tab3.push_back(mk(1'b1, 1'b1, 1'b0, 3'b101, 1'b1, 3'b000, 1'b0, 2'd0));
        tab3.push_back(mk(1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 3'b001, 1'b1, 2'd0));
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset rr1", 64'(rr1), 64'd0);
        check("reset valid1", 64'(v1), 64'd0);
        check("reset src1", 64'(s1), 64'd0);
        check("reset data1", 64'(d1), 64'd0);
        check("reset valid3", 64'(v3), 64'd0);
        check("reset rr3", 64'(rr3), 64'd0);

        for (int i = 0; i < tab1.size(); i++)
            run_vec(tab1[i], $sformatf("t1[%0d]", i));

`ifndef ISSUE_ARB_PRIO0_EN
        // Reset while holding a stalled instruction from requester 1.
        run_vec(mk(1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 3'b010, 1'b1, 2'd1), "mid load");
        run_vec(mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 2'd1), "mid hold");
        run_vec(mk(1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 3'b000, 1'b0, 2'd0), "mid rst");
        check("mid rst src", 64'(s1), 64'd0);
        check("mid rst data", 64'(d1), 64'd0);
        run_vec(mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0), "post rst");

        for (int i = 0; i < tab3.size(); i++)
            run_vec(tab3[i], $sformatf("t3[%0d]", i));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
